toggle_hs_rx: RTL and testbench

Receiving end of the two-phase (toggle) handshake whose sender flips a single request bit once per transfer. The block synchronises the incoming toggle and detects each flip as one transfer event. It captures the accompanying data word, presents it downstream on a valid/ready interface, and answers the sender by toggling an acknowledge bit once the word is consumed. It also counts accepted transfers and flags protocol overruns.

---
 rtl/toggle_hs_pkg.sv | 14 +
 rtl/toggle_hs_rx_tgl_sync.sv | 29 ++
 rtl/toggle_hs_rx.sv | 127 ++++++++++++
 tb/tb_toggle_hs_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the two-phase toggle handshake sender/receiver pair.
package toggle_hs_pkg;

    typedef enum logic [1:0] {
        WARM = 2'd0,
        IDLE = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned WARM_CNT_W      = $clog2(SYNC_STAGES_MAX + 1);

endpackage

// File: rtl/toggle_hs_rx_tgl_sync.sv
// Multi-flop synchroniser for a single toggle bit, synchronous reset to 0.
module tgl_sync
    import toggle_hs_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    // Out-of-range requests are clamped to the legal synchroniser depth.
    localparam int unsigned N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                                (STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : STAGES;

    logic [N-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/toggle_hs_rx.sv
// Receiver of a two-phase toggle handshake: sync, capture, valid/ready out, toggle ack back.
module toggle_hs_rx
    import toggle_hs_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic              overrun,
    input  logic              clr_overrun
);

    logic                  w_req_s;
    logic                  w_evt;
    logic                  r_req_prev;
    state_e                r_state;
    state_e                w_state_nxt;
    logic [WARM_CNT_W-1:0] r_warm_cnt;
    logic [WARM_CNT_W-1:0] w_warm_nxt;
    logic                  r_ack;
    logic                  w_ack_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic [DATA_W-1:0]     r_data;
    logic [DATA_W-1:0]     w_data_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_overrun;
    logic                  w_ovr_set;
    logic                  w_ovr_nxt;

    tgl_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .i_d (req_tgl),
        .o_q (w_req_s)
    );

    assign w_evt = w_req_s ^ r_req_prev;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_warm_nxt  = r_warm_cnt;
        w_ack_nxt   = r_ack;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_ovr_set   = 1'b0;

        case (r_state)
            WARM: begin
                // Align ack with the settled request so an idle link leaves warm-up balanced.
                if (r_warm_cnt == WARM_CNT_W'(SYNC_STAGES)) begin
                    w_ack_nxt   = w_req_s;
                    w_state_nxt = IDLE;
                end else begin
                    w_warm_nxt = r_warm_cnt + WARM_CNT_W'(1);
                end
            end
            IDLE: begin
                if (w_evt) begin
                    w_data_nxt  = req_data;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_ack_nxt   = ~r_ack;
                    w_state_nxt = IDLE;
                end
                // A flip while a word is still held is dropped and flagged.
                if (w_evt) begin
                    w_ovr_set = 1'b1;
                end
            end
            default: begin
                w_state_nxt = WARM;
            end
        endcase

        w_ovr_nxt = w_ovr_set | (r_overrun & ~clr_overrun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WARM;
            r_warm_cnt <= '0;
            r_req_prev <= 1'b0;
            r_ack      <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_nxt;
            r_req_prev <= w_req_s;
            r_ack      <= w_ack_nxt;
            r_valid    <= w_valid_nxt;
            r_data     <= w_data_nxt;
            r_cnt      <= w_cnt_nxt;
            r_overrun  <= w_ovr_nxt;
        end
    end

    assign ack_tgl   = r_ack;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign evt_cnt   = r_cnt;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Directed plus randomized bench for toggle_hs_rx against a transaction-level model.
module tb_toggle_hs_rx;

    localparam int unsigned DW   = 8;
    localparam int unsigned SYNC = 2;
    localparam int unsigned CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_tgl;
    logic [DW-1:0] req_data;
    logic          ack_tgl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] evt_cnt;
    logic          overrun;
    logic          clr_overrun;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: words accepted since reset, expected ack level, last captured word.
    int            m_acc;
    logic          m_ack;
    logic [DW-1:0] m_data;
    logic [DW-1:0] d;
    int            w;

    toggle_hs_rx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_tgl     (req_tgl),
        .req_data    (req_data),
        .ack_tgl     (ack_tgl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .evt_cnt     (evt_cnt),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
        return 32'(m_acc % (1 << CW));
    endfunction

    task automatic send(input logic [DW-1:0] val);
        req_data = val;
        req_tgl  = ~req_tgl;
    endtask

    initial begin
        rst = 1'b1; req_tgl = 1'b1; req_data = '0;
        out_ready = 1'b0; clr_overrun = 1'b0;
        m_acc = 0; m_ack = 1'b0; m_data = '0;

        // Reset with request held high.
        repeat (3) tick();
        check("rst_ack", 32'(ack_tgl), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        check("rst_cnt", 32'(evt_cnt), 32'(0));
        check("rst_ovr", 32'(overrun), 32'(0));
        rst = 1'b0;
        repeat (SYNC) tick();
        check("warm_ack_early", 32'(ack_tgl), 32'(0));
        tick();
        m_ack = req_tgl;
        check("warm_ack", 32'(ack_tgl), 32'(m_ack));
        repeat (4) tick();
        check("warm_no_evt_valid", 32'(out_valid), 32'(0));
        check("warm_no_evt_cnt", 32'(evt_cnt), exp_cnt());

        // Single transfer with ready already high.
        out_ready = 1'b1;
        send(8'hA5);
        repeat (SYNC) tick();
        check("lat_not_yet", 32'(out_valid), 32'(0));
        tick();
        m_acc++; m_data = 8'hA5;
        check("single_valid", 32'(out_valid), 32'(1));
        check("single_data", 32'(out_data), 32'(m_data));
        check("single_cnt", 32'(evt_cnt), exp_cnt());
        check("single_ack_wait", 32'(ack_tgl), 32'(m_ack));
        tick();
        m_ack = ~m_ack;
        check("single_done_valid", 32'(out_valid), 32'(0));
        check("single_ack", 32'(ack_tgl), 32'(m_ack));
        check("single_data_hold", 32'(out_data), 32'(m_data));

        // Backpressure: word held for 10 cycles, then exactly one ack flip.
        out_ready = 1'b0;
        d = DW'($urandom);
        send(d);
        repeat (SYNC + 1) tick();
        m_acc++; m_data = d;
        check("bp_cnt", 32'(evt_cnt), exp_cnt());
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_data", 32'(out_data), 32'(m_data));
            check("bp_ack", 32'(ack_tgl), 32'(m_ack));
            tick();
        end
        out_ready = 1'b1;
        tick();
        m_ack = ~m_ack;
        check("bp_release_valid", 32'(out_valid), 32'(0));
        check("bp_release_ack", 32'(ack_tgl), 32'(m_ack));
        repeat (3) tick();
        check("bp_one_flip", 32'(ack_tgl), 32'(m_ack));
        out_ready = 1'b0;

        // Overrun: second flip while holding is flagged, not captured.
        d = DW'($urandom);
        send(d);
        repeat (SYNC + 1) tick();
        m_acc++; m_data = d;
        check("ovr_first_cnt", 32'(evt_cnt), exp_cnt());
        send(~d);
        repeat (SYNC + 1) tick();
        check("ovr_set", 32'(overrun), 32'(1));
        check("ovr_cnt", 32'(evt_cnt), exp_cnt());
        check("ovr_data", 32'(out_data), 32'(m_data));
        check("ovr_valid", 32'(out_valid), 32'(1));
        // Clear coinciding with a new overrun event: set wins.
        send(d ^ 8'h0F);
        repeat (SYNC) tick();
        clr_overrun = 1'b1;
        tick();
        check("ovr_set_wins", 32'(overrun), 32'(1));
        tick();
        clr_overrun = 1'b0;
        check("ovr_clear", 32'(overrun), 32'(0));
        // Event on the same edge as the handshake: handshake completes, event is overrun.
        send(d ^ 8'hF0);
        repeat (SYNC) tick();
        out_ready = 1'b1;
        tick();
        m_ack = ~m_ack;
        out_ready = 1'b0;
        check("coin_valid", 32'(out_valid), 32'(0));
        check("coin_ack", 32'(ack_tgl), 32'(m_ack));
        check("coin_ovr", 32'(overrun), 32'(1));
        check("coin_cnt", 32'(evt_cnt), exp_cnt());
        repeat (4) tick();
        check("coin_no_capture", 32'(out_valid), 32'(0));
        check("coin_no_count", 32'(evt_cnt), exp_cnt());
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("coin_clr", 32'(overrun), 32'(0));

        // Randomized transfers; the counter wraps through 2^CW along the way.
        for (int k = 0; k < 20; k++) begin
            d = DW'($urandom);
            send(d);
            repeat (SYNC + 1) tick();
            m_acc++; m_data = d;
            check("rnd_valid", 32'(out_valid), 32'(1));
            check("rnd_data", 32'(out_data), 32'(m_data));
            check("rnd_cnt", 32'(evt_cnt), exp_cnt());
            w = int'($urandom_range(0, 3));
            repeat (w) tick();
            check("rnd_hold", 32'(out_valid), 32'(1));
            out_ready = 1'b1;
            tick();
            m_ack = ~m_ack;
            out_ready = 1'b0;
            check("rnd_done", 32'(out_valid), 32'(0));
            check("rnd_ack", 32'(ack_tgl), 32'(m_ack));
            tick();
        end
        check("rnd_no_ovr", 32'(overrun), 32'(0));
        check("wrap_cnt", 32'(evt_cnt), 32'(m_acc % 16));

        // Reset while a word is held.
        d = DW'($urandom);
        send(d);
        repeat (SYNC + 1) tick();
        check("mid_hold_valid", 32'(out_valid), 32'(1));
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_ack", 32'(ack_tgl), 32'(0));
        check("mid_rst_data", 32'(out_data), 32'(0));
        check("mid_rst_cnt", 32'(evt_cnt), 32'(0));
        rst = 1'b0;
        m_acc = 0;
        repeat (SYNC + 1) tick();
        m_ack = req_tgl;
        check("mid_warm_ack", 32'(ack_tgl), 32'(m_ack));
        for (int i = 0; i < 5; i++) begin
            check("mid_no_spurious", 32'(out_valid), 32'(0));
            tick();
        end
        check("mid_cnt_zero", 32'(evt_cnt), exp_cnt());
        d = DW'($urandom);
        send(d);
        repeat (SYNC + 1) tick();
        m_acc++; m_data = d;
        check("post_valid", 32'(out_valid), 32'(1));
        check("post_data", 32'(out_data), 32'(m_data));
        check("post_cnt", 32'(evt_cnt), exp_cnt());
        out_ready = 1'b1;
        tick();
        m_ack = ~m_ack;
        out_ready = 1'b0;
        check("post_ack", 32'(ack_tgl), 32'(m_ack));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
